// File: rtl/controle_turno.sv
// controle_turno: shares one two-digit countdown timer between players A and B.
// Generates the 1 s count enable and the load strobe for the timer, swaps
// turns on the active player's button and ends the game on the last timeout.
module controle_turno #(
    parameter int CLK_DIV     = 50_000_000,
    parameter int PRESET_DEZ  = 3,
    parameter int PRESET_UNID = 0,
    parameter int MAX_FALTAS  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       botao_a,
    input  logic       botao_b,
    input  logic       pausa,
    input  logic       fim,
    input  logic       quinze,
    output logic       tick,
    output logic       carga,
    output logic [1:0] dez_preset,
    output logic [3:0] unid_preset,
    output logic       jogador,
    output logic       alerta,
    output logic       estouro,
    output logic       fim_jogo,
    output logic       vencedor,
    output logic [1:0] faltas_a,
    output logic [1:0] faltas_b
);

    localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [1:0]    FALTAS_LIM = 2'(MAX_FALTAS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE,
        TIMEOUT,
        OVER
    } estado_t;

    estado_t       estado, estado_prox;
    logic [PW-1:0] presc, presc_prox;
    logic          jog_q, jog_prox;
    logic [1:0]    fa_q, fa_prox;
    logic [1:0]    fb_q, fb_prox;

    logic prev_ini, prev_a, prev_b, prev_pausa;
    logic ev_ini, ev_a, ev_b, ev_pausa, ev_ativo;
    logic [1:0] faltas_ativo;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    // Previous button levels; reset to 1 so a button held through reset is not an event.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_ini   <= 1'b1;
            prev_a     <= 1'b1;
            prev_b     <= 1'b1;
            prev_pausa <= 1'b1;
        end else begin
            prev_ini   <= iniciar;
            prev_a     <= botao_a;
            prev_b     <= botao_b;
            prev_pausa <= pausa;
        end
    end

    assign ev_ini       = iniciar & ~prev_ini;
    assign ev_a         = botao_a & ~prev_a;
    assign ev_b         = botao_b & ~prev_b;
    assign ev_pausa     = pausa & ~prev_pausa;
    assign ev_ativo     = jog_q ? ev_b : ev_a;
    // In TIMEOUT this already holds the count incremented on entry.
    assign faltas_ativo = jog_q ? fb_q : fa_q;

    // State, prescaler, active player and timeout counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= IDLE;
            presc  <= '0;
            jog_q  <= 1'b0;
            fa_q   <= 2'd0;
            fb_q   <= 2'd0;
        end else begin
            estado <= estado_prox;
            presc  <= presc_prox;
            jog_q  <= jog_prox;
            fa_q   <= fa_prox;
            fb_q   <= fb_prox;
        end
    end

    // Next-state and strobe generation; fim outranks every button in RUN.
    always_comb begin
        estado_prox = estado;
        presc_prox  = presc;
        jog_prox    = jog_q;
        fa_prox     = fa_q;
        fb_prox     = fb_q;
        tick        = 1'b0;
        carga       = 1'b0;
        case (estado)
            IDLE: begin
                if (ev_ini) estado_prox = LOAD;
            end
            LOAD: begin
                carga       = 1'b1;
                presc_prox  = '0;
                estado_prox = RUN;
            end
            RUN: begin
                if (fim) begin
                    // Timer already at 00: charge the timeout, no tick this cycle.
                    estado_prox = TIMEOUT;
                    if (jog_q) fb_prox = sat_inc(fb_q);
                    else       fa_prox = sat_inc(fa_q);
                end else begin
                    tick       = (presc == PRESC_MAX);
                    presc_prox = tick ? '0 : presc + 1'b1;
                    if (ev_ativo) begin
                        jog_prox    = ~jog_q;
                        estado_prox = LOAD;
                    end else if (ev_pausa) begin
                        estado_prox = PAUSE;
                    end
                end
            end
            PAUSE: begin
                // Prescaler frozen so the second resumes where it stopped.
                if (ev_pausa) estado_prox = RUN;
            end
            TIMEOUT: begin
                if (faltas_ativo == FALTAS_LIM) begin
                    estado_prox = OVER;
                end else if (ev_ini) begin
                    jog_prox    = ~jog_q;
                    estado_prox = LOAD;
                end
            end
            OVER: begin
                estado_prox = OVER;
            end
            default: begin
                estado_prox = IDLE;
            end
        endcase
    end

    assign dez_preset  = 2'(PRESET_DEZ);
    assign unid_preset = 4'(PRESET_UNID);
    assign jogador     = jog_q;
    assign faltas_a    = fa_q;
    assign faltas_b    = fb_q;
    assign alerta      = quinze & ((estado == RUN) | (estado == PAUSE));
    assign estouro     = (estado == TIMEOUT);
    assign fim_jogo    = (estado == OVER);
    // The player who timed out last stays in jogador, so the winner is the other one.
    assign vencedor    = fim_jogo & ~jog_q;

endmodule

// File: tb/tb_controle_turno.sv
// Bench for controle_turno: directed stimulus pushes the expected tick/carga
// pulses (cycle, kind, active player) into a queue; a negedge monitor pops
// and compares whenever the DUT emits one. Level outputs are spot-checked.
module tb_controle_turno;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, botao_a = 1'b0, botao_b = 1'b0, pausa = 1'b0;
    logic       fim = 1'b0, quinze = 1'b0;
    logic       tick, carga, jogador, alerta, estouro, fim_jogo, vencedor;
    logic [1:0] dez_preset, faltas_a, faltas_b;
    logic [3:0] unid_preset;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int   c;
        logic tk;
        logic cg;
        logic jg;
    } ev_t;
    ev_t q[$];

    controle_turno #(
        .CLK_DIV(4), .PRESET_DEZ(3), .PRESET_UNID(0), .MAX_FALTAS(3)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botao_a(botao_a),
        .botao_b(botao_b), .pausa(pausa), .fim(fim), .quinze(quinze),
        .tick(tick), .carga(carga), .dez_preset(dez_preset),
        .unid_preset(unid_preset), .jogador(jogador), .alerta(alerta),
        .estouro(estouro), .fim_jogo(fim_jogo), .vencedor(vencedor),
        .faltas_a(faltas_a), .faltas_b(faltas_b)
    );

    initial forever #5 clock = ~clock;

    // Cycle k is the interval after the k-th rising edge.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_ev(input int c, input logic tk, input logic cg, input logic jg);
        ev_t e;
        e.c = c; e.tk = tk; e.cg = cg; e.jg = jg;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every tick/carga pulse must match the head of the queue.
    always @(negedge clock) begin
        if (!reset) begin
            while (q.size() > 0 && q[0].c < cyc) begin
                ev_t m;
                m = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse cyc=%0d exp_tick=%0b exp_carga=%0b", m.c, m.tk, m.cg);
            end
            if (tick || carga) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d tick=%0b carga=%0b", cyc, tick, carga);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.c != cyc || e.tk !== tick || e.cg !== carga || e.jg !== jogador) begin
                        errors++;
                        $display("FAIL pulse got cyc=%0d tick=%0b carga=%0b jog=%0b exp cyc=%0d tick=%0b carga=%0b jog=%0b",
                                 cyc, tick, carga, jogador, e.c, e.tk, e.cg, e.jg);
                    end
                end
            end
        end
    end

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_tick"}, tick, 0);
        chk({nm, "_carga"}, carga, 0);
        chk({nm, "_jogador"}, jogador, 0);
        chk({nm, "_faltas_a"}, faltas_a, 0);
        chk({nm, "_faltas_b"}, faltas_b, 0);
        chk({nm, "_estouro"}, estouro, 0);
        chk({nm, "_fim_jogo"}, fim_jogo, 0);
        chk({nm, "_vencedor"}, vencedor, 0);
        chk({nm, "_dez_preset"}, dez_preset, 3);
        chk({nm, "_unid_preset"}, unid_preset, 0);
    endtask

    initial begin
        int s, u, w, x, y;
        // Reset with iniciar held high: release must not count as an event.
        iniciar = 1'b1;
        step(3);
        @(negedge clock);
        chk_reset_vals("rst");
        step(1);
        reset = 1'b0;
        step(4);
        iniciar = 1'b0;
        step(2);
        @(negedge clock);
        chk("held_ini_no_start_alerta", alerta, 0);

        // quinze in IDLE gives no warning.
        quinze = 1'b1;
        @(negedge clock);
        chk("alerta_idle", alerta, 0);
        step(1);
        quinze = 1'b0;

        // Start: one carga, then ticks on RUN cycles 4, 8, 12.
        s = cyc;
        iniciar = 1'b1;
        push_ev(s + 1, 0, 1, 0);
        push_ev(s + 5, 1, 0, 0);
        push_ev(s + 9, 1, 0, 0);
        push_ev(s + 13, 1, 0, 0);
        step(1);
        iniciar = 1'b0;
        step(13);

        // Inactive player's button is ignored.
        botao_b = 1'b1;
        step(1);
        botao_b = 1'b0;
        @(negedge clock);
        chk("b_ignored_jogador", jogador, 0);

        // A ends turn: B active, fresh load.
        s = cyc;
        botao_a = 1'b1;
        push_ev(s + 1, 0, 1, 1);
        step(1);
        botao_a = 1'b0;
        @(negedge clock);
        chk("a_swap_jogador", jogador, 1);
        step(2);

        // Pause on the second RUN cycle, hold 20 cycles, resume: tick 2 cycles later.
        pausa = 1'b1;
        step(1);
        pausa = 1'b0;
        step(19);
        u = cyc;
        pausa = 1'b1;
        push_ev(u + 2, 1, 0, 1);
        step(1);
        pausa = 1'b0;
        quinze = 1'b1;
        @(negedge clock);
        chk("alerta_run", alerta, 1);
        step(1);
        quinze = 1'b0;
        step(1);

        // B hands turn back to A.
        botao_b = 1'b1;
        push_ev(u + 4, 0, 1, 0);
        step(1);
        botao_b = 1'b0;
        step(4);

        // fim together with A's button on the tick cycle: timeout wins, no tick.
        fim = 1'b1;
        botao_a = 1'b1;
        step(1);
        fim = 1'b0;
        botao_a = 1'b0;
        @(negedge clock);
        chk("to1_estouro", estouro, 1);
        chk("to1_faltas_a", faltas_a, 1);
        chk("to1_jogador", jogador, 0);
        chk("to1_faltas_b", faltas_b, 0);
        step(3);
        @(negedge clock);
        chk("to1_wait_estouro", estouro, 1);

        // iniciar resumes with B; fim right after the load (preset 00 case).
        w = cyc;
        iniciar = 1'b1;
        push_ev(w + 1, 0, 1, 1);
        step(1);
        iniciar = 1'b0;
        step(1);
        fim = 1'b1;
        step(1);
        fim = 1'b0;
        @(negedge clock);
        chk("b1_faltas_b", faltas_b, 1);
        chk("b1_estouro", estouro, 1);
        chk("b1_jogador", jogador, 1);

        // A turn, then B times out a second time.
        x = cyc;
        iniciar = 1'b1;
        push_ev(x + 1, 0, 1, 0);
        step(1);
        iniciar = 1'b0;
        step(1);
        botao_a = 1'b1;
        push_ev(x + 3, 0, 1, 1);
        step(1);
        botao_a = 1'b0;
        step(2);
        fim = 1'b1;
        step(1);
        fim = 1'b0;
        @(negedge clock);
        chk("b2_faltas_b", faltas_b, 2);
        chk("b2_faltas_a", faltas_a, 1);

        // A turn, then B's third timeout ends the game.
        y = cyc;
        iniciar = 1'b1;
        push_ev(y + 1, 0, 1, 0);
        step(1);
        iniciar = 1'b0;
        step(2);
        botao_a = 1'b1;
        push_ev(y + 4, 0, 1, 1);
        step(1);
        botao_a = 1'b0;
        step(2);
        fim = 1'b1;
        step(1);
        fim = 1'b0;
        @(negedge clock);
        chk("b3_estouro", estouro, 1);
        chk("b3_faltas_b", faltas_b, 3);
        step(1);
        @(negedge clock);
        chk("over_fim_jogo", fim_jogo, 1);
        chk("over_vencedor", vencedor, 0);
        chk("over_jogador", jogador, 1);
        chk("over_estouro", estouro, 0);

        // Everything ignored once over.
        iniciar = 1'b1; botao_a = 1'b1; botao_b = 1'b1; pausa = 1'b1; quinze = 1'b1;
        step(1);
        iniciar = 1'b0; botao_a = 1'b0; botao_b = 1'b0; pausa = 1'b0;
        step(5);
        @(negedge clock);
        chk("over_hold_fim_jogo", fim_jogo, 1);
        chk("over_hold_faltas_b", faltas_b, 3);
        chk("over_hold_faltas_a", faltas_a, 1);
        chk("over_alerta", alerta, 0);
        quinze = 1'b0;

        // Reset clears everything.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clock);
        chk_reset_vals("rst2");
        step(3);
        @(negedge clock);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
